// File: rtl/core_pkg.sv
// Shared definitions for the arbitration and payload-select blocks.
package core_pkg;

    // Width of a binary index that selects one of n channels.
    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned ARB_WIDTH = 32;

    typedef struct packed {
        logic                 valid;
        logic [ARB_WIDTH-1:0] data;
    } arb_req_t;

endpackage

// File: rtl/mux.sv
// N-way payload multiplexer; channel is the outer index of the packed input.
module mux
    import core_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_INS = 4
) (
    input  logic [N_INS-1:0][WIDTH-1:0]      ins,
    input  logic [sel_width(N_INS)-1:0]      sel,
    output logic [WIDTH-1:0]                 out
);

    localparam int unsigned SEL_WIDTH = sel_width(N_INS);

    // Compare against each existing index so a non-power-of-2 count never reads past the array.
    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < N_INS; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                out = ins[i];
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first valid channel after ptr, wrapping at N_INS-1.
module rr_pick
    import core_pkg::*;
#(
    parameter int unsigned N_INS = 4
) (
    input  logic [N_INS-1:0]            valid,
    input  logic [sel_width(N_INS)-1:0] ptr,
    output logic [sel_width(N_INS)-1:0] gnt,
    output logic [N_INS-1:0]            gnt_oh,
    output logic                        any_req
);

    localparam int unsigned SEL_WIDTH = sel_width(N_INS);

    always_comb begin
        logic                 found;
        int unsigned          idx;
        logic [SEL_WIDTH-1:0] sidx;
        gnt     = '0;
        gnt_oh  = '0;
        any_req = |valid;
        found   = 1'b0;
        idx     = 0;
        sidx    = '0;
        for (int unsigned k = 1; k <= N_INS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_INS) begin
                idx = idx - N_INS;
            end
            sidx = SEL_WIDTH'(idx);
            if (!found && valid[sidx]) begin
                found        = 1'b1;
                gnt          = sidx;
                gnt_oh[sidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter over valid/ready channels feeding a one-entry output register.
module rr_arb_mux
    import core_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_INS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_INS-1:0]                 in_valid,
    output logic [N_INS-1:0]                 in_ready,
    input  logic [N_INS-1:0][WIDTH-1:0]      in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [sel_width(N_INS)-1:0]      out_src
);

    localparam int unsigned SEL_WIDTH = sel_width(N_INS);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] gnt;
    logic [N_INS-1:0]     gnt_oh;
    logic                 any_req;
    logic                 load;
    logic [WIDTH-1:0]     win_data;

    rr_pick #(
        .N_INS (N_INS)
    ) u_pick (
        .valid   (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_oh  (gnt_oh),
        .any_req (any_req)
    );

    mux #(
        .WIDTH (WIDTH),
        .N_INS (N_INS)
    ) u_mux (
        .ins (in_data),
        .sel (gnt),
        .out (win_data)
    );

    // Output register is empty or being drained, so it can take a new payload this cycle.
    assign load = !out_valid | out_ready;

    always_comb begin
        in_ready = '0;
        if (!rst && load && any_req) begin
            in_ready = gnt_oh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_WIDTH'(N_INS - 1);
        end else if (load) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= gnt;
                ptr       <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed checks of rr_arb_mux at N_INS=4 and N_INS=3, WIDTH=8.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0]      v4 = '0;
    logic [3:0]      r4;
    logic [3:0][7:0] d4 = '0;
    logic            ov4;
    logic            ordy4 = 1'b0;
    logic [7:0]      od4;
    logic [1:0]      os4;

    logic [2:0]      v3 = '0;
    logic [2:0]      r3;
    logic [2:0][7:0] d3 = '0;
    logic            ov3;
    logic            ordy3 = 1'b0;
    logic [7:0]      od3;
    logic [1:0]      os3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .N_INS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (r4),
        .in_data   (d4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .out_data  (od4),
        .out_src   (os4)
    );

    rr_arb_mux #(.WIDTH(8), .N_INS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v3),
        .in_ready  (r3),
        .in_data   (d3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .out_data  (od3),
        .out_src   (os3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_src4 [5];
        logic [7:0] exp_dat4 [5];
        logic [1:0] exp_src3 [5];
        exp_src4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat4 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        exp_src3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        // Reset state, with requests already present.
        v4 = 4'b1111;
        d4 = {8'h33, 8'h22, 8'h11, 8'h00};
        ordy4 = 1'b1;
        #2 rst = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(ov4), 32'd0);
        check("rst_out_src", 32'(os4), 32'd0);
        check("rst_out_data", 32'(od4), 32'd0);
        check("rst_in_ready", 32'(r4), 32'd0);
        rst = 1'b0;
        #1;
        check("rr_first_ready", 32'(r4), 32'b0001);

        // Full rotation with all channels valid.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_out_src", 32'(os4), 32'(exp_src4[i]));
            check("rr_out_data", 32'(od4), 32'(exp_dat4[i]));
            check("rr_out_valid", 32'(ov4), 32'd1);
        end

        // Backpressure: ch2 accepted, then stall while ch1 waits.
        v4 = 4'b0100;
        d4 = {8'h33, 8'hA5, 8'h5C, 8'h00};
        #1;
        check("bp_ready_ch2", 32'(r4), 32'b0100);
        step();
        check("bp_src_ch2", 32'(os4), 32'd2);
        v4 = 4'b0010;
        ordy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold_ready", 32'(r4), 32'd0);
            check("bp_hold_data", 32'(od4), 32'hA5);
            check("bp_hold_src", 32'(os4), 32'd2);
            check("bp_hold_valid", 32'(ov4), 32'd1);
            if (i < 2) step();
        end
        step();
        ordy4 = 1'b1;
        #1;
        check("bp_release_ready", 32'(r4), 32'b0010);
        step();
        check("bp_next_src", 32'(os4), 32'd1);
        check("bp_next_data", 32'(od4), 32'h5C);

        // Single requester granted back-to-back.
        for (int i = 0; i < 4; i++) begin
            check("single_ready", 32'(r4), 32'b0010);
            step();
            check("single_valid", 32'(ov4), 32'd1);
            check("single_src", 32'(os4), 32'd1);
        end

        // Idle drain.
        v4 = 4'b0001;
        d4 = {8'h33, 8'hA5, 8'h5C, 8'h7E};
        #1;
        check("drain_ready", 32'(r4), 32'b0001);
        step();
        check("drain_load_data", 32'(od4), 32'h7E);
        v4 = 4'b0000;
        #1;
        check("drain_idle_ready", 32'(r4), 32'd0);
        step();
        check("drain_valid", 32'(ov4), 32'd0);
        check("drain_data_hold", 32'(od4), 32'h7E);
        check("drain_src_hold", 32'(os4), 32'd0);

        // Asynchronous reset while a payload is held.
        v4 = 4'b1000;
        d4 = {8'h99, 8'hA5, 8'h5C, 8'h7E};
        step();
        check("ar_loaded_src", 32'(os4), 32'd3);
        check("ar_loaded_valid", 32'(ov4), 32'd1);
        v4 = 4'b1111;
        ordy4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid_async", 32'(ov4), 32'd0);
        check("ar_src_async", 32'(os4), 32'd0);
        check("ar_ready_in_rst", 32'(r4), 32'd0);
        step();
        rst = 1'b0;
        ordy4 = 1'b1;
        #1;
        check("ar_first_ready", 32'(r4), 32'b0001);
        step();
        check("ar_first_src", 32'(os4), 32'd0);

        // Three-channel wrap.
        v3 = 3'b111;
        d3 = {8'hC2, 8'hB1, 8'hA0};
        ordy3 = 1'b1;
        #1;
        check("n3_first_ready", 32'(r3), 32'b001);
        for (int i = 0; i < 5; i++) begin
            step();
            check("n3_out_src", 32'(os3), 32'(exp_src3[i]));
            check("n3_out_data", 32'(od3), 32'(8'hA0 + 8'h11 * exp_src3[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
